// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among execution-unit result
// ports, with the winner registered onto the CDB one cycle after the handshake.

package expipe_pkg;
    localparam int ROB_IDX_W = 6;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      value;
        logic                 exception;
    } cdb_data_t;
endpackage

module cdb_arbiter
    import expipe_pkg::*;
#(
    parameter  int N_REQ   = 4,
    localparam int PTR_LEN = $clog2(N_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               flush_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  cdb_data_t          req_data_i [N_REQ],
    input  logic               rob_ready_i,
    output logic               cdb_valid_o,
    output cdb_data_t          cdb_data_o,
    output logic [PTR_LEN-1:0] grant_idx_o
);

    logic               valid_reg, valid_next;
    cdb_data_t          data_reg,  data_next;
    logic [PTR_LEN-1:0] idx_reg,   idx_next;
    logic [PTR_LEN-1:0] ptr_reg,   ptr_next;

    logic [N_REQ-1:0]   upper_mask;
    logic [N_REQ-1:0]   upper_req;
    logic               lo_any, hi_any;
    logic [PTR_LEN-1:0] lo_idx, hi_idx;
    logic [PTR_LEN-1:0] win_idx;
    logic               stage_free;
    logic               grant_en;

    // Requesters at or above the pointer get first pick; the rest wrap around.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (PTR_LEN'(gi) >= ptr_reg);
        end
    endgenerate

    assign upper_req = req_valid_i & upper_mask;

    always_comb begin
        lo_any = 1'b0;
        lo_idx = '0;
        hi_any = 1'b0;
        hi_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                lo_any = 1'b1;
                lo_idx = PTR_LEN'(i);
            end
            if (upper_req[i]) begin
                hi_any = 1'b1;
                hi_idx = PTR_LEN'(i);
            end
        end
    end

    assign win_idx     = hi_any ? hi_idx : lo_idx;
    assign stage_free  = !valid_reg || rob_ready_i;
    assign grant_en    = lo_any && stage_free && !flush_i;
    assign req_ready_o = grant_en ? (N_REQ'(1) << win_idx) : '0;

    always_comb begin
        valid_next = valid_reg;
        data_next  = data_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        if (flush_i) begin
            valid_next = 1'b0;
        end else if (grant_en) begin
            // A consume and a new grant in the same cycle overwrite without a bubble.
            valid_next = 1'b1;
            data_next  = req_data_i[win_idx];
            idx_next   = win_idx;
            ptr_next   = win_idx + 1'b1;
        end else if (valid_reg && rob_ready_i) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            idx_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign cdb_valid_o = valid_reg;
    assign cdb_data_o  = data_reg;
    assign grant_idx_o = idx_reg;

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        $onehot0(req_ready_o));

    a_ready_implies_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (req_ready_o & ~req_valid_i) == '0);

    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (cdb_valid_o && !rob_ready_i) |=> $stable(cdb_data_o));

endmodule
